// File: rtl/floo_lookahead_port_buf_if.sv
// Handshake bundle between the upstream link, the lookahead port buffer and the switch.
// The buffer connects through the slave modport; the driving side uses master.
interface floo_lookahead_port_buf_if #(
  parameter int unsigned NumRoutes = 5,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned DirWidth  = 3
);
  // upstream link side
  logic                 valid_i;
  logic                 ready_o;
  logic [FlitWidth-1:0] data_i;
  logic                 head_i;
  logic                 last_i;
  logic [DirWidth-1:0]  lookahead_i;
  logic                 credit_o;

  // switch side
  logic                 valid_o;
  logic                 ready_i;
  logic [FlitWidth-1:0] data_o;
  logic                 last_o;
  logic [NumRoutes-1:0] route_o;

  modport slave (
    input  valid_i, data_i, head_i, last_i, lookahead_i, ready_i,
    output ready_o, credit_o, valid_o, data_o, last_o, route_o
  );

  modport master (
    output valid_i, data_i, head_i, last_i, lookahead_i, ready_i,
    input  ready_o, credit_o, valid_o, data_o, last_o, route_o
  );
endinterface

// File: rtl/floo_lookahead_port_buf.sv
// Router input-port flit FIFO that turns the upstream lookahead into a one-hot switch request
// and holds it for the whole packet. Optional same-cycle bypass via FLOO_LA_BYPASS_EN.
//
// state  | meaning
// IDLE   | front flit must be a head; request follows its stored lookahead
// LOCKED | head already switched; body/tail flits reuse the latched request
module floo_lookahead_port_buf #(
  parameter int unsigned NumRoutes = 5,
  parameter int unsigned Depth     = 4,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned DirWidth  = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  floo_lookahead_port_buf_if.slave   bus,
  output logic [$clog2(Depth+1)-1:0] fill_o,
  output logic                       err_o
);

  localparam int unsigned FillWidth = $clog2(Depth + 1);
  localparam int unsigned PtrWidth  = $clog2(Depth);
  localparam logic [NumRoutes-1:0] RouteLocal = NumRoutes'(1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e state_q, state_d;
  logic [NumRoutes-1:0] lock_q, lock_d;

  logic [FlitWidth-1:0] data_mem [Depth];
  logic [DirWidth-1:0]  la_mem   [Depth];
  logic [Depth-1:0]     head_mem;
  logic [Depth-1:0]     last_mem;

  logic [PtrWidth-1:0]  rd_ptr_q, wr_ptr_q;
  logic [FillWidth-1:0] fill_q;
  logic                 credit_q;
  logic                 err_q;

  logic                 bypass;
  logic                 ready;
  logic                 push;
  logic                 pop;
  logic                 pop_fifo;
  logic                 front_valid;
  logic [FlitWidth-1:0] front_data;
  logic                 front_head;
  logic                 front_last;
  logic [DirWidth-1:0]  front_la;
  logic [NumRoutes-1:0] front_route;
  logic                 err_set;

  function automatic logic la_legal(input logic [DirWidth-1:0] la);
    return 32'(la) < NumRoutes;
  endfunction

  // Out-of-range lookaheads fall back to the local port.
  function automatic logic [NumRoutes-1:0] decode_route(input logic [DirWidth-1:0] la);
    logic [NumRoutes-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NumRoutes); i++) begin
      if (32'(la) == 32'(i)) r[i] = 1'b1;
    end
    if (!la_legal(la)) r = RouteLocal;
    return r;
  endfunction

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

`ifdef FLOO_LA_BYPASS_EN
  assign bypass = (fill_q == '0) && bus.valid_i && !rst_i;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    if (bypass) begin
      front_data = bus.data_i;
      front_head = bus.head_i;
      front_last = bus.last_i;
      front_la   = bus.lookahead_i;
    end else begin
      front_data = data_mem[rd_ptr_q];
      front_head = head_mem[rd_ptr_q];
      front_last = last_mem[rd_ptr_q];
      front_la   = la_mem[rd_ptr_q];
    end
  end

  assign ready       = !rst_i && (fill_q < FillWidth'(Depth));
  assign front_valid = !rst_i && ((fill_q != '0) || bypass);
  assign pop         = front_valid && bus.ready_i;
  // A bypassed flit that is granted straight away never occupies an entry.
  assign pop_fifo    = pop && !bypass;
  assign push        = bus.valid_i && ready && !(bypass && bus.ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    front_route = '0;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (front_head) begin
          front_route = decode_route(front_la);
          err_set     = front_valid && !la_legal(front_la);
        end else begin
          front_route = RouteLocal;
          err_set     = front_valid;
        end
        if (pop && front_head && !front_last) begin
          state_d = LOCKED;
          lock_d  = front_route;
        end
      end
      LOCKED: begin
        front_route = lock_q;
        if (pop && front_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.data_i;
      la_mem[wr_ptr_q]   <= bus.lookahead_i;
      head_mem[wr_ptr_q] <= bus.head_i;
      last_mem[wr_ptr_q] <= bus.last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push)     wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_fifo) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop_fifo})
        2'b10:   fill_q <= fill_q + FillWidth'(1);
        2'b01:   fill_q <= fill_q - FillWidth'(1);
        default: fill_q <= fill_q;
      endcase
      credit_q <= pop;
      err_q    <= err_q | err_set;
    end
  end

  assign bus.ready_o  = ready;
  assign bus.valid_o  = front_valid;
  assign bus.data_o   = front_data;
  assign bus.last_o   = front_last;
  assign bus.route_o  = front_valid ? front_route : '0;
  assign bus.credit_o = credit_q && !rst_i;
  assign fill_o       = rst_i ? '0 : fill_q;
  assign err_o        = err_q && !rst_i;

endmodule

// File: tb/tb_floo_lookahead_port_buf.sv
// Directed-vector bench for floo_lookahead_port_buf (Depth 4, five routes).
module tb_floo_lookahead_port_buf;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fill;
  logic       err;
  int         n_cmp = 0;
  int         n_err = 0;

  floo_lookahead_port_buf_if #(.NumRoutes(5), .FlitWidth(64), .DirWidth(3)) bus ();

  floo_lookahead_port_buf #(.NumRoutes(5), .Depth(4), .FlitWidth(64), .DirWidth(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .fill_o(fill),
    .err_o (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, vin, hd, lst;
    logic [2:0]  la;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic [4:0]  er;
    logic        el;
    logic [15:0] ed;
    logic        erd;
    logic [2:0]  ef;
    logic        ec, ee;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, vin, hd, lst, input logic [2:0] la,
                             input logic [15:0] d, input logic rdy, input logic ev,
                             input logic [4:0] er, input logic el, input logic [15:0] ed,
                             input logic erd, input logic [2:0] ef, input logic ec, ee);
    vec_t x;
    x = '{r, vin, hd, lst, la, d, rdy, ev, er, el, ed, erd, ef, ec, ee};
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, vin, hd, lst, input logic [2:0] la,
                       input logic [15:0] d, input logic rdy);
    rst             = r;
    bus.valid_i     = vin;
    bus.head_i      = hd;
    bus.last_i      = lst;
    bus.lookahead_i = la;
    bus.data_i      = 64'(d);
    bus.ready_i     = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // reset hold with valid_i high: nothing may be accepted
    vecs.push_back(v(1,1,1,0,2,'h11,1, 0,5'b00000,0,'h0, 0,0,0,0));
    // head la=2, body (stray la=3), body, tail, streaming
    vecs.push_back(v(0,1,1,0,2,'hA0,1, 0,5'b00000,0,'h0,  1,0,0,0));
    vecs.push_back(v(0,1,0,0,3,'hA1,1, 1,5'b00100,0,'hA0, 1,1,0,0));
    vecs.push_back(v(0,1,0,0,0,'hA2,1, 1,5'b00100,0,'hA1, 1,1,1,0));
    vecs.push_back(v(0,1,0,1,0,'hA3,1, 1,5'b00100,0,'hA2, 1,1,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b00100,1,'hA3, 1,1,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,0,0));
    // single-flit la=1, then head la=3 with tail: no stale lock
    vecs.push_back(v(0,1,1,1,1,'hB0,1, 0,5'b00000,0,'h0,  1,0,0,0));
    vecs.push_back(v(0,1,1,0,3,'hB1,1, 1,5'b00010,1,'hB0, 1,1,0,0));
    vecs.push_back(v(0,1,0,1,1,'hB2,1, 1,5'b01000,0,'hB1, 1,1,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b01000,1,'hB2, 1,1,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,0,0));
    // fill to Depth with ready_i=0 (pointers wrap), rejected push, then drain
    vecs.push_back(v(0,1,1,1,0,'hC0,0, 0,5'b00000,0,'h0,  1,0,0,0));
    vecs.push_back(v(0,1,1,1,1,'hC1,0, 1,5'b00001,1,'hC0, 1,1,0,0));
    vecs.push_back(v(0,1,1,1,2,'hC2,0, 1,5'b00001,1,'hC0, 1,2,0,0));
    vecs.push_back(v(0,1,1,1,3,'hC3,0, 1,5'b00001,1,'hC0, 1,3,0,0));
    vecs.push_back(v(0,1,1,1,4,'hFF,0, 1,5'b00001,1,'hC0, 0,4,0,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b00001,1,'hC0, 0,4,0,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 0, 1,5'b00010,1,'hC1, 1,3,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b00010,1,'hC1, 1,3,0,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b00100,1,'hC2, 1,2,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b01000,1,'hC3, 1,1,1,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,1,0));
    // illegal lookahead 6: whole packet to port 0, err sticky
    vecs.push_back(v(0,1,1,0,6,'hD0,1, 0,5'b00000,0,'h0,  1,0,0,0));
    vecs.push_back(v(0,1,0,0,2,'hD1,1, 1,5'b00001,0,'hD0, 1,1,0,0));
    vecs.push_back(v(0,1,0,1,3,'hD2,1, 1,5'b00001,0,'hD1, 1,1,1,1));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b00001,1,'hD2, 1,1,1,1));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,1,1));
    vecs.push_back(v(0,0,0,0,0,'h0, 0, 0,5'b00000,0,'h0,  1,0,0,1));
    // lock on la=2, buffer 3 flits, reset mid-packet, then fresh head la=4
    vecs.push_back(v(0,1,1,0,2,'hE0,0, 0,5'b00000,0,'h0,  1,0,0,1));
    vecs.push_back(v(0,1,0,0,0,'hE1,1, 1,5'b00100,0,'hE0, 1,1,0,1));
    vecs.push_back(v(0,1,0,0,0,'hE2,0, 1,5'b00100,0,'hE1, 1,1,1,1));
    vecs.push_back(v(0,1,0,0,0,'hE3,0, 1,5'b00100,0,'hE1, 1,2,0,1));
    vecs.push_back(v(1,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  0,0,0,0));
    vecs.push_back(v(0,1,1,1,4,'hE5,1, 0,5'b00000,0,'h0,  1,0,0,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b10000,1,'hE5, 1,1,0,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,1,0));
    // non-head flit at the front in IDLE: protocol error, local port
    vecs.push_back(v(0,1,0,1,3,'hF0,1, 0,5'b00000,0,'h0,  1,0,0,0));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b00001,1,'hF0, 1,1,0,0));
    vecs.push_back(v(0,1,1,1,3,'hF2,1, 0,5'b00000,0,'h0,  1,0,1,1));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 1,5'b01000,1,'hF2, 1,1,0,1));
    vecs.push_back(v(0,0,0,0,0,'h0, 1, 0,5'b00000,0,'h0,  1,0,1,1));

    drive(1, 0, 0, 0, 3'd0, 16'h0, 0);
    next_cycle();
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vin, vecs[i].hd, vecs[i].lst, vecs[i].la, vecs[i].d, vecs[i].rdy);
      #1;
      chk("valid_o",  i, 64'(bus.valid_o),  64'(vecs[i].ev));
      chk("route_o",  i, 64'(bus.route_o),  64'(vecs[i].er));
      chk("ready_o",  i, 64'(bus.ready_o),  64'(vecs[i].erd));
      chk("fill_o",   i, 64'(fill),         64'(vecs[i].ef));
      chk("credit_o", i, 64'(bus.credit_o), 64'(vecs[i].ec));
      chk("err_o",    i, 64'(err),          64'(vecs[i].ee));
      if (vecs[i].ev) begin
        chk("data_o", i, bus.data_o,        64'(vecs[i].ed));
        chk("last_o", i, 64'(bus.last_o),   64'(vecs[i].el));
      end
      next_cycle();
    end

    // latency from an empty buffer: head+tail la=4 granted immediately
    drive(1, 0, 0, 0, 3'd0, 16'h0, 0);
    next_cycle();
    drive(0, 1, 1, 1, 3'd4, 16'h55, 1);
    #1;
`ifdef FLOO_LA_BYPASS_EN
    chk("bypass valid_o", 100, 64'(bus.valid_o), 64'd1);
    chk("bypass route_o", 100, 64'(bus.route_o), 64'b10000);
    chk("bypass data_o",  100, bus.data_o,       64'h55);
    next_cycle();
    drive(0, 0, 0, 0, 3'd0, 16'h0, 1);
    #1;
    chk("bypass fill_o",   101, 64'(fill),         64'd0);
    chk("bypass credit_o", 101, 64'(bus.credit_o), 64'd1);
    chk("bypass valid_o",  101, 64'(bus.valid_o),  64'd0);
`else
    chk("latency valid_o", 100, 64'(bus.valid_o), 64'd0);
    chk("latency route_o", 100, 64'(bus.route_o), 64'd0);
    next_cycle();
    drive(0, 0, 0, 0, 3'd0, 16'h0, 1);
    #1;
    chk("latency valid_o", 101, 64'(bus.valid_o),  64'd1);
    chk("latency route_o", 101, 64'(bus.route_o),  64'b10000);
    chk("latency data_o",  101, bus.data_o,        64'h55);
    chk("latency fill_o",  101, 64'(fill),         64'd1);
    next_cycle();
    #1;
    chk("latency credit_o", 102, 64'(bus.credit_o), 64'd1);
    chk("latency fill_o",   102, 64'(fill),         64'd0);
`endif
    next_cycle();
    #1;
    chk("final credit_o", 103, 64'(bus.credit_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/floo_lookahead_port_buf.md
FLOO_LOOKAHEAD_PORT_BUF -- requirements
Module: floo_lookahead_port_buf

Interface
REQ-001 Parameter NumRoutes, default 5, the number of router output ports; route index 0 is the local/eject port.
REQ-002 Parameter Depth, default 4, flit buffer entries; legal range 2..16.
REQ-003 Parameter FlitWidth, default 64, payload bits per flit.
REQ-004 Parameter DirWidth, default 3, width of the lookahead direction field.
REQ-005 clk_i  in  1  the single clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  reset, synchronous and active-high.
REQ-007 valid_i  in  1  upstream flit valid.
REQ-008 ready_o  out  1  buffer can accept a flit.
REQ-009 data_i  in  FlitWidth  flit payload.
REQ-010 head_i  in  1  flit is a packet head and carries a valid lookahead.
REQ-011 last_i  in  1  flit is the packet tail; head_i and last_i together mark a single-flit packet.
REQ-012 lookahead_i  in  DirWidth  output port precomputed by the upstream router for this router.
REQ-013 valid_o  out  1  buffered flit available to the switch.
REQ-014 ready_i  in  1  switch grant; a pop happens on valid_o && ready_i.
REQ-015 data_o, last_o  out  FlitWidth, 1  front flit payload and tail flag.
REQ-016 route_o  out  NumRoutes  one-hot output-port request for the front flit; all zero when valid_o is 0.
REQ-017 credit_o  out  1  one-cycle credit-return pulse to the upstream router.
REQ-018 fill_o  out  $clog2(Depth+1)  current occupancy.
REQ-019 err_o  out  1  sticky illegal-lookahead flag.

Function
REQ-020 Push on valid_i && ready_o; ready_o SHALL equal (fill < Depth), with no combinational path from ready_i.
REQ-021 The buffer SHALL be a circular FIFO; read and write pointers wrap from Depth-1 to 0.
REQ-022 A simultaneous push and pop SHALL leave fill_o unchanged and preserve FIFO order.
REQ-023 The block SHALL have route states IDLE and LOCKED.
REQ-024 In IDLE, the front flit SHALL have head_i set; route_o is then the one-hot decode of its stored lookahead.
REQ-025 IDLE to LOCKED: when a head without last is popped, the block latches the route.
REQ-026 In LOCKED, body and tail flits SHALL drive the latched route, ignoring their lookahead bits.
REQ-027 LOCKED to IDLE: when the last flit is popped.
REQ-028 A head+last flit popped in IDLE SHALL leave the state in IDLE.
REQ-029 A front flit without head in IDLE is a protocol violation: set err_o, and drive route index 0.
REQ-030 A lookahead value >= NumRoutes on a head SHALL set err_o; that head and its packet route to index 0.
REQ-031 credit_o SHALL pulse high in the cycle after each pop, exactly once per popped flit.
REQ-032 Registered-path latency: a flit pushed in cycle N is visible on valid_o in cycle N+1.

Reset
REQ-033 While rst_i is high, the block SHALL clear both pointers and fill_o to 0, set state to IDLE, and clear err_o and credit_o to 0.
REQ-034 During reset, valid_o SHALL be 0, route_o 0, and ready_o 0.
REQ-035 Reset asserted mid-packet SHALL discard all buffered flits and the latched route; no credits are issued for discarded flits.

Configuration
REQ-036 Macro FLOO_LA_BYPASS_EN selects bypass behaviour.
REQ-037 When defined: if the FIFO is empty and valid_i is 1, valid_o, data_o, last_o and route_o SHALL be driven combinationally from the inputs.
REQ-038 When defined: a bypassed flit granted by ready_i in the same cycle is not written, and still produces a credit_o pulse in the next cycle.
REQ-039 When not defined: every flit SHALL pass through storage, giving 1-cycle minimum latency per REQ-032.

Verification
REQ-040 Head (lookahead=2) + 2 body + tail, ready_i=1 -> route_o=5'b00100 for all 4 flits; 4 credit pulses; state ends IDLE.
REQ-041 Push Depth=4 flits with ready_i=0 -> fill_o=4, ready_o=0; one pop -> ready_o=1 the next cycle.
REQ-042 Single-flit packet head+last lookahead=1, then head lookahead=3 -> route_o 5'b00010 then 5'b01000; no stale lock.
REQ-043 Head with lookahead=6 -> err_o=1 and stays 1; route_o=5'b00001 for the whole packet.
REQ-044 Assert rst_i with 3 flits buffered mid-packet -> fill_o=0, valid_o=0, no credit; next head routes by its own lookahead.
REQ-045 FLOO_LA_BYPASS_EN defined, empty FIFO, push head lookahead=4 with ready_i=1 -> valid_o and route_o=5'b10000 in the same cycle; fill_o stays 0; credit next cycle.
